// File: rtl/ntt_butterfly_pipe.sv
// Three-stage pipelined NTT butterfly (CT forward / GS inverse) mod Q with valid/ready and tag sideband.
// Optional completed-operation counter on op_cnt_o enabled by defining BFLY_OPCNT_EN.
module ntt_butterfly_pipe #(
    parameter int W     = 23,
    parameter int Q     = 8380417,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [W:0]       a_i,
    input  logic [W:0]       b_i,
    input  logic [W-1:0]     twiddle_i,
    input  logic             sel_red_i,
    input  logic             sel_butterfly_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [W-1:0]     a_out_o,
    output logic [W-1:0]     b_out_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [31:0]      op_cnt_o
);

    localparam logic [W:0]     Q_N  = (W+1)'(Q);
    localparam logic [2*W-1:0] Q_P  = (2*W)'(Q);
    // Barrett constant floor(2^(2W)/Q); assumes 2^(W-1) < Q < 2^W so it fits in W+1 bits
    localparam logic [2*W:0]   MU_F = ((2*W+1)'(1'b1) << (2*W)) / (2*W+1)'(Q);
    localparam logic [W:0]     MU   = (W+1)'(MU_F);

    function automatic logic [W-1:0] red_q(input logic [W:0] x);
        logic [W:0] r;
        if (x >= Q_N) r = x - Q_N;
        else          r = x;
        return W'(r);
    endfunction

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_N) s = s - Q_N;
        else          s = s;
        return W'(s);
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + Q_N - {1'b0, y};
        return W'(s);
    endfunction

    // Barrett reduction of x < Q^2; the quotient estimate is low by at most 2
    function automatic logic [W-1:0] barrett(input logic [2*W-1:0] x);
        logic [W:0]       q1;
        logic [2*W+1:0]   q2;
        logic [W:0]       q3;
        logic [2*W-1:0]   qq;
        logic [W+1:0]     r;
        q1 = (W+1)'(x >> (W-1));
        q2 = {{(W+1){1'b0}}, q1} * {{(W+1){1'b0}}, MU};
        q3 = (W+1)'(q2 >> (W+1));
        qq = {{(W-1){1'b0}}, q3} * Q_P;
        r  = (W+2)'(x - qq);
        if (r >= {1'b0, Q_N}) r = r - {1'b0, Q_N};
        else                  r = r;
        if (r >= {1'b0, Q_N}) r = r - {1'b0, Q_N};
        else                  r = r;
        return W'(r);
    endfunction

    logic             stall_s;
    logic [W-1:0]     ra_s, rb_s, x1_s, y1_s, p_s, ao_s, bo_s;
    logic             v1_r, m1_r, v2_r, m2_r;
    logic [W-1:0]     x1_r, y1_r, w1_r, x2_r;
    logic [2*W-1:0]   prod2_r;
    logic [TAG_W-1:0] t1_r, t2_r;

    assign stall_s = valid_o && !ready_i;
    assign ready_o = !stall_s;

    // Stage-1 operand conditioning: optional pre-reduction, GS sum/difference
    always_comb begin
        ra_s = W'(a_i);
        rb_s = W'(b_i);
        x1_s = '0;
        y1_s = '0;
        if (sel_red_i) begin
            ra_s = red_q(a_i);
            rb_s = red_q(b_i);
        end else begin
            ra_s = W'(a_i);
            rb_s = W'(b_i);
        end
        if (sel_butterfly_i) begin
            x1_s = mod_add(ra_s, rb_s);
            y1_s = mod_sub(ra_s, rb_s);
        end else begin
            x1_s = ra_s;
            y1_s = rb_s;
        end
    end

    // Stage-3 result forming from the reduced product
    always_comb begin
        p_s  = barrett(prod2_r);
        ao_s = '0;
        bo_s = '0;
        if (m2_r) begin
            ao_s = x2_r;
            bo_s = p_s;
        end else begin
            ao_s = mod_add(x2_r, p_s);
            bo_s = mod_sub(x2_r, p_s);
        end
    end

    // Pipeline registers; the whole pipe freezes on a global stall
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1_r    <= 1'b0;
            m1_r    <= 1'b0;
            t1_r    <= '0;
            x1_r    <= '0;
            y1_r    <= '0;
            w1_r    <= '0;
            v2_r    <= 1'b0;
            m2_r    <= 1'b0;
            t2_r    <= '0;
            x2_r    <= '0;
            prod2_r <= '0;
            valid_o <= 1'b0;
            a_out_o <= '0;
            b_out_o <= '0;
            tag_o   <= '0;
        end else if (!stall_s) begin
            v1_r    <= valid_i;
            m1_r    <= sel_butterfly_i;
            t1_r    <= tag_i;
            x1_r    <= x1_s;
            y1_r    <= y1_s;
            w1_r    <= twiddle_i;
            v2_r    <= v1_r;
            m2_r    <= m1_r;
            t2_r    <= t1_r;
            x2_r    <= x1_r;
            prod2_r <= {{W{1'b0}}, y1_r} * {{W{1'b0}}, w1_r};
            valid_o <= v2_r;
            a_out_o <= ao_s;
            b_out_o <= bo_s;
            tag_o   <= t2_r;
        end else begin
            v1_r    <= v1_r;
            v2_r    <= v2_r;
            valid_o <= valid_o;
        end
    end

`ifdef BFLY_OPCNT_EN
    // Completed-operation counter, counts output handshakes and wraps
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_cnt_o <= 32'd0;
        end else if (valid_o && ready_i) begin
            op_cnt_o <= op_cnt_o + 32'd1;
        end else begin
            op_cnt_o <= op_cnt_o;
        end
    end
`else
    assign op_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Scoreboard bench for ntt_butterfly_pipe: expectations pushed at input handshake, popped by an output monitor.
module tb_ntt_butterfly_pipe;
    localparam int W = 23;
    localparam int Q = 8380417;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_i, ready_o, sel_red_i, sel_butterfly_i, valid_o, ready_i;
    logic [W:0]       a_i, b_i;
    logic [W-1:0]     twiddle_i, a_out_o, b_out_o;
    logic [TAG_W-1:0] tag_i, tag_o;
    logic [31:0]      op_cnt_o;

    typedef struct {
        longint a;
        longint b;
        longint tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   pops = 0;
    bit   rnd_done;

    ntt_butterfly_pipe #(.W(W), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .twiddle_i(twiddle_i), .sel_red_i(sel_red_i),
        .sel_butterfly_i(sel_butterfly_i), .tag_i(tag_i), .valid_o(valid_o),
        .ready_i(ready_i), .a_out_o(a_out_o), .b_out_o(b_out_o), .tag_o(tag_o),
        .op_cnt_o(op_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint exp_cnt();
`ifdef BFLY_OPCNT_EN
        return longint'(pops);
`else
        return 0;
`endif
    endfunction

    // Reference butterfly from the arithmetic definition
    function automatic void model(input longint a, input longint b, input longint w,
                                  input bit red, input bit gs, output longint ea, output longint eb);
        longint p, d;
        if (red && a >= Q) a = a - Q;
        if (red && b >= Q) b = b - Q;
        if (!gs) begin
            p  = (b * w) % Q;
            ea = (a + p) % Q;
            eb = (a - p + Q) % Q;
        end else begin
            d  = (a - b + Q) % Q;
            ea = (a + b) % Q;
            eb = (d * w) % Q;
        end
    endfunction

    task automatic send(input longint a, input longint b, input longint w, input bit red,
                        input bit gs, input longint tag, input longint ea, input longint eb);
        exp_t e;
        bit   ok;
        a_i = (W+1)'(a); b_i = (W+1)'(b); twiddle_i = W'(w);
        sel_red_i = red; sel_butterfly_i = gs; tag_i = TAG_W'(tag);
        valid_i = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            e.a = ea; e.b = eb; e.tag = tag;
            sb.push_back(e);
        end else begin
            chk("accept_timeout", 0, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_m(input longint a, input longint b, input longint w, input bit red,
                          input bit gs, input longint tag);
        longint ea, eb;
        model(a, b, w, red, gs, ea, eb);
        send(a, b, w, red, gs, tag, ea, eb);
    endtask

    task automatic send_rand(input longint tag);
        bit red;
        red = 1'($urandom_range(0, 1));
        send_m(red ? longint'($urandom_range(0, 2*Q-1)) : longint'($urandom_range(0, Q-1)),
               red ? longint'($urandom_range(0, 2*Q-1)) : longint'($urandom_range(0, Q-1)),
               longint'($urandom_range(0, Q-1)), red, 1'($urandom_range(0, 1)), tag);
    endtask

    task automatic drain();
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_left", sb.size(), 0);
    endtask

    // Output monitor: pops the scoreboard on each output handshake and checks hold stability
    initial begin
        bit     held;
        longint ha, hb, ht;
        exp_t   e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && held) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_a", a_out_o, ha);
                chk("stall_b", b_out_o, hb);
                chk("stall_tag", tag_o, ht);
            end
            if (rst_n && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual_tag=%0d required=none", tag_o);
                end else begin
                    e = sb.pop_front();
                    chk("a_out", a_out_o, e.a);
                    chk("b_out", b_out_o, e.b);
                    chk("tag_o", tag_o, e.tag);
                    chk("op_cnt", op_cnt_o, exp_cnt());
                    pops++;
                end
            end
            held = rst_n && valid_o && !ready_i;
            ha = a_out_o; hb = b_out_o; ht = tag_o;
        end
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; twiddle_i = '0; sel_red_i = 1'b0; sel_butterfly_i = 1'b0; tag_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_a", a_out_o, 0);
        chk("rst_b", b_out_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_cnt", op_cnt_o, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", ready_o, 1);
        @(posedge clk); #1;

        // Directed cases with latency check on the first
        send(5, 3, 2, 1'b0, 1'b0, 8'h11, 11, Q-1);
        valid_i = 1'b0;
        @(negedge clk); chk("lat_c1", valid_o, 0);
        @(negedge clk); chk("lat_c2", valid_o, 0);
        @(negedge clk); chk("lat_c3", valid_o, 1);
        @(posedge clk); #1;
        send(5, 3, 2, 1'b0, 1'b1, 8'h21, 8, 4);
        send(3, 5, 1, 1'b0, 1'b1, 8'h22, 8, Q-2);
        send(8380418, 8380419, 1, 1'b1, 1'b0, 8'h31, 3, Q-1);
        send_m(Q-1, Q-1, Q-1, 1'b0, 1'b0, 8'h41);
        send_m(Q-1, 0, Q-1, 1'b0, 1'b1, 8'h42);
        send_m(2*Q-1, 2*Q-1, Q-1, 1'b1, 1'b1, 8'h43);
        send_m(0, Q-1, Q-1, 1'b0, 1'b0, 8'h44);
        drain();

        // Backpressure: 6 back-to-back ops, 5-cycle hold on the first result
        ready_i = 1'b0;
        fork
            begin
                for (int t = 1; t <= 6; t++) send_rand(t);
                valid_i = 1'b0;
            end
            begin
                for (int n = 0; n < 20 && !valid_o; n++) @(negedge clk);
                for (int n = 0; n < 5; n++) begin
                    chk("bp_ready_low", ready_o, 0);
                    chk("bp_tag_frozen", tag_o, 1);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                ready_i = 1'b1;
                for (int n = 0; n < 6; n++) begin
                    @(negedge clk);
                    chk("bp_stream_valid", valid_o, 1);
                end
            end
        join
        drain();

        // Reset with two operations in flight
        send_m(7, 9, 3, 1'b0, 1'b0, 8'h51);
        send_m(9, 7, 3, 1'b0, 1'b1, 8'h52);
        valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_a", a_out_o, 0);
        chk("mid_rst_b", b_out_o, 0);
        chk("mid_rst_tag", tag_o, 0);
        chk("mid_rst_cnt", op_cnt_o, 0);
        sb.delete();
        pops = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("post_rst_idle", valid_o, 0);
        end
        @(posedge clk); #1;

        // Ten ops with random downstream stalls, then counter check
        rnd_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 10; t++) send_rand(t + 100);
                valid_i = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    ready_i = ($urandom_range(0, 2) != 0);
                end
                ready_i = 1'b1;
            end
        join
        drain();
        repeat (3) @(posedge clk);
        #1;
`ifdef BFLY_OPCNT_EN
        chk("op_cnt_10", op_cnt_o, 10);
`else
        chk("op_cnt_off", op_cnt_o, 0);
`endif

        // Longer random run with input gaps and stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 60; t++) begin
                    send_rand(t);
                    if ($urandom_range(0, 3) == 0) begin
                        valid_i = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                valid_i = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
                ready_i = 1'b1;
            end
        join
        drain();
        repeat (3) @(posedge clk);
        #1;
`ifdef BFLY_OPCNT_EN
        chk("op_cnt_final", op_cnt_o, 70);
`else
        chk("op_cnt_final", op_cnt_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ntt_butterfly_pipe.md
Name: ntt_butterfly_pipe

Overview:
- Pipelined, parametrised successor of the combinational NTT butterfly.
- Performs one Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT) butterfly per cycle modulo Q, with optional input pre-reduction.
- Uses a valid/ready stream interface and carries a tag through the pipeline.
- Sits between the coefficient-memory read port and the write-back path of the NTT engine.

Parameters:
- W, 23, coefficient width; outputs are W bits, inputs are W+1 bits (lazy values).
- Q, 8380417, prime modulus; Q < 2^W.
- TAG_W, 8, width of the sideband tag carried with each operation.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  input operation valid.
- ready_o  out  1  block accepts input this cycle.
- a_i  in  W+1  operand a.
- b_i  in  W+1  operand b.
- twiddle_i  in  W  twiddle factor, < Q.
- sel_red_i  in  1  1: reduce a_i, b_i mod Q before use (inputs must be < 2Q).
- sel_butterfly_i  in  1  0: CT, 1: GS.
- tag_i  in  TAG_W  sideband tag.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- a_out_o  out  W  result a, in [0,Q).
- b_out_o  out  W  result b, in [0,Q).
- tag_o  out  TAG_W  tag of the result.
- op_cnt_o  out  32  completed-operation count (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-low; one clock domain.
- On reset: all stage valids 0, valid_o=0, a_out_o=0, b_out_o=0, tag_o=0, op_cnt_o=0. ready_o=1 as soon as reset deasserts.
- Pipeline has three stages with a fixed latency of 3 cycles from input handshake to valid_o when not stalled.
  - S1 register: optional reduction (x>=Q ? x-Q : x); in GS mode, precompute s=(a+b) mod Q and d=(a-b) mod Q.
  - S2 register: product. CT: b*twiddle. GS: d*twiddle. Width 2W.
  - S3 register: modular reduction of the product to p in [0,Q). CT: a_out=(a+p) mod Q, b_out=(a-p) mod Q. GS: a_out=s, b_out=p.
- Any exact reduction is allowed (Barrett recommended); outputs must be bit-exact.
- With sel_red_i=0 and a_i or b_i >= Q, the result is unspecified. Benches do not drive this case.
- Handshake uses a global stall: stall = valid_o && !ready_i.
  - ready_o = !stall.
  - When stalled, every stage register and the outputs hold.
  - Input is accepted only when valid_i && ready_o.
  - Bubbles are not collapsed.
- Operations leave in acceptance order; the tag and mode travel with the data.
- Output data, tag and mode are stable while valid_o=1 and ready_i=0.
- valid_i may fall while the pipeline drains; in-flight operations still complete.
- Simultaneous output handshake and input acceptance in the same cycle is legal, giving full throughput of 1 op/cycle.
- Reset mid-operation: all in-flight operations are discarded, valid_o drops asynchronously, and no stale result appears after release.

Optional Feature:
- Macro: BFLY_OPCNT_EN.
- Defined: op_cnt_o is a 32-bit register that increments on each output handshake (valid_o && ready_i), wraps 0xFFFFFFFF -> 0, and resets to 0.
- Undefined: op_cnt_o is tied to 0 and no counter logic exists.

Test Plan:
- CT, sel_red=0: a=5, b=3, w=2, tag=0x11 -> 3 cycles later valid_o=1, a_out=11, b_out=8380416, tag_o=0x11.
- GS, sel_red=0: a=5, b=3, w=2 -> a_out=8, b_out=4. Also a=3, b=5, w=1 -> a_out=8, b_out=8380415.
- Pre-reduction, CT, sel_red=1: a=8380418, b=8380419, w=1 -> a_out=3, b_out=8380416.
- Backpressure: stream tags 1..6 back-to-back; hold ready_i=0 for 5 cycles after the first valid_o.
  - ready_o=0 and outputs frozen on tag 1 during the hold.
  - After release, tags 1..6 emerge in order, one per cycle, with no loss or duplication.
- Reset mid-flight: accept 2 ops, assert rst_n_i low before either exits.
  - valid_o=0 immediately and all outputs 0.
  - After release with valid_i=0 for 5 cycles, valid_o stays 0.
- BFLY_OPCNT_EN defined: 10 completed ops with interleaved ready_i stalls -> op_cnt_o=10; stalled cycles do not count. Undefined: op_cnt_o=0 throughout.
